ifid_hazard_ctrl: RTL

- Pipeline control unit that sequences the IF/ID pipeline register and the PC in the 5-stage 32-bit pipeline.
- Produces the PC load, IF/ID load and clear, and ID/EX bubble strobes for three conditions: load-use hazards, instruction-memory wait states and taken branches resolved in ID.
- Tracks whether IF/ID holds a branch delay-slot instruction and drives the ta_instr flag to downstream stages.

---
 rtl/ifid_hazard_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ifid_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifid_hazard_ctrl
// Purpose  : IF/ID and PC sequencing for load-use stalls, fetch wait states
//            and ID-resolved taken branches, with delay-slot tracking.
//            Optional statistics counters: define PIPE_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_hazard_ctrl #(
    parameter int LOAD_LAT      = 1,
    parameter int DELAY_SLOT    = 1,
    parameter int FETCH_TIMEOUT = 255
`ifdef PIPE_CTRL_STATS_EN
    ,
    parameter int STAT_W        = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_branch_taken,
    input  logic       imem_ready,
    output logic       pc_ld,
    output logic       pc_sel_target,
    output logic       ifid_ld,
    output logic       ifid_clr,
    output logic       idex_bubble,
    output logic       ta_instr,
    output logic       fetch_err,
    output logic       slot_err,
    output logic [1:0] state
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_lu,
    output logic [STAT_W-1:0] stat_fwait,
    output logic [STAT_W-1:0] stat_br
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_STALL   = 2'd1,
        FETCH_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] c_LU_RELOAD = 3'(LOAD_LAT - 1);
    localparam logic [7:0] c_TIMEOUT   = 8'(FETCH_TIMEOUT);
    localparam logic       c_DS        = (DELAY_SLOT != 0);

    state_t     state_q, state_d;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       ta_q, ta_d;
    logic       ferr_q, ferr_d;
    logic       serr_q, serr_d;

    logic w_lu, w_br_live;
    logic w_pc_ld, w_sel, w_ifid_ld, w_ifid_clr, w_bubble, w_stall;

    assign w_lu = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    // A taken branch sitting in a delay slot is not redirected.
    assign w_br_live = id_branch_taken & ~ta_q;

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        serr_d     = serr_q;
        w_pc_ld    = 1'b0;
        w_sel      = 1'b0;
        w_ifid_ld  = 1'b0;
        w_ifid_clr = 1'b0;
        w_bubble   = 1'b0;
        w_stall    = 1'b0;

        if (state_q == LU_STALL) begin
            w_stall  = 1'b1;
            lu_cnt_d = lu_cnt_q - 3'd1;
            if (lu_cnt_q == 3'd1) begin
                state_d = RUN;
            end
        end else begin
            if (w_lu) begin
                w_stall = 1'b1;
            end else if (!imem_ready) begin
                if (w_br_live) begin
                    w_bubble = 1'b1;
                end else begin
                    w_ifid_clr = 1'b1;
                end
            end else if (w_br_live) begin
                w_pc_ld = 1'b1;
                w_sel   = 1'b1;
                if (c_DS) begin
                    w_ifid_ld = 1'b1;
                end else begin
                    w_ifid_clr = 1'b1;
                end
            end else begin
                w_pc_ld   = 1'b1;
                w_ifid_ld = 1'b1;
            end

            if (!w_lu && id_branch_taken && ta_q) begin
                serr_d = 1'b1;
            end

            // A hazard seen in RUN takes priority over a missing fetch.
            if (!imem_ready && !(state_q == RUN && w_lu)) begin
                state_d = FETCH_WAIT;
                if (state_q == RUN) begin
                    wait_cnt_d = 8'd1;
                end else if (wait_cnt_q != c_TIMEOUT) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end else begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
                if (w_lu && (LOAD_LAT > 1)) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = c_LU_RELOAD;
                end
            end
        end

        ferr_d = ferr_q | (wait_cnt_d == c_TIMEOUT);

        if (w_ifid_ld) begin
            ta_d = w_sel;
        end else if (w_ifid_clr) begin
            ta_d = 1'b0;
        end else begin
            ta_d = ta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            lu_cnt_q   <= 3'd0;
            wait_cnt_q <= 8'd0;
            ta_q       <= 1'b0;
            ferr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ta_q       <= ta_d;
            ferr_q     <= ferr_d;
            serr_q     <= serr_d;
        end
    end

    assign pc_ld         = w_pc_ld & ~reset;
    assign pc_sel_target = w_sel & ~reset;
    assign ifid_ld       = w_ifid_ld & ~reset;
    assign ifid_clr      = w_ifid_clr & ~reset;
    assign idex_bubble   = (w_bubble | w_stall) & ~reset;
    assign ta_instr      = ta_q;
    assign fetch_err     = ferr_q;
    assign slot_err      = serr_q;
    assign state         = state_q;

`ifdef PIPE_CTRL_STATS_EN
    logic [STAT_W-1:0] stat_lu_q, stat_fwait_q, stat_br_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lu_q    <= '0;
            stat_fwait_q <= '0;
            stat_br_q    <= '0;
        end else begin
            if (w_stall && (stat_lu_q != '1)) begin
                stat_lu_q <= stat_lu_q + 1'b1;
            end
            if (!imem_ready && (stat_fwait_q != '1)) begin
                stat_fwait_q <= stat_fwait_q + 1'b1;
            end
            if (w_sel && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + 1'b1;
            end
        end
    end

    assign stat_lu    = stat_lu_q;
    assign stat_fwait = stat_fwait_q;
    assign stat_br    = stat_br_q;
`endif

endmodule
`default_nettype wire
